// File: rtl/conv1d_pkg.sv
// Shared types and constants for the conv1d requantization stage.
package conv1d_pkg;

   localparam int INT32_SIZE = 32;
   localparam int BYTE_SIZE  = 8;
   localparam int SHIFT_W    = 6;

   localparam logic signed [INT32_SIZE-1:0] INT32_MIN = 32'sh8000_0000;
   localparam logic signed [INT32_SIZE-1:0] INT32_MAX = 32'sh7fff_ffff;

   typedef enum logic [2:0] {
      CFG_MULT    = 3'd0,
      CFG_SHIFT   = 3'd1,
      CFG_OFFSET  = 3'd2,
      CFG_ACT_MIN = 3'd3,
      CFG_ACT_MAX = 3'd4
   } cfg_sel_e;

   localparam logic signed [INT32_SIZE-1:0] MULT_RST    = 32'sh4000_0000;
   localparam logic signed [SHIFT_W-1:0]    SHIFT_RST   = '0;
   localparam logic signed [INT32_SIZE-1:0] OFFSET_RST  = '0;
   localparam logic signed [INT32_SIZE-1:0] ACT_MIN_RST = -32'sd128;
   localparam logic signed [INT32_SIZE-1:0] ACT_MAX_RST = 32'sd127;

   function automatic logic [BYTE_SIZE-1:0] low_byte(
      input logic signed [INT32_SIZE:0] v
   );
      return v[BYTE_SIZE-1:0];
   endfunction

endpackage

// File: rtl/conv1d_srdhm.sv
// Two-stage saturating rounding doubling high multiply (S2 product, S3 round).
module conv1d_srdhm
   import conv1d_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         in_valid,
   input  logic                         in_last,
   input  logic signed [INT32_SIZE-1:0] in_x,
   input  logic signed [INT32_SIZE-1:0] in_mult,
   output logic                         out_valid,
   output logic                         out_last,
   output logic signed [INT32_SIZE-1:0] out_h,
   output logic                         busy
);

   localparam logic signed [63:0] NUDGE_POS = 64'sh0000_0000_4000_0000;
   localparam logic signed [63:0] NUDGE_NEG = 64'shffff_ffff_c000_0001;
   localparam logic signed [63:0] TRUNC_ADJ = 64'sh0000_0000_7fff_ffff;

   logic                         s2_valid_q, s2_valid_d;
   logic                         s2_last_q, s2_last_d;
   logic                         s2_sat_q, s2_sat_d;
   logic signed [63:0]           s2_p_q, s2_p_d;
   logic                         s3_valid_q, s3_valid_d;
   logic                         s3_last_q, s3_last_d;
   logic signed [INT32_SIZE-1:0] s3_h_q, s3_h_d;
   logic signed [63:0]           sum, rnd;
   logic signed [INT32_SIZE-1:0] h;

   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_last_d  = s2_last_q;
      s2_sat_d   = s2_sat_q;
      s2_p_d     = s2_p_q;
      s3_valid_d = s3_valid_q;
      s3_last_d  = s3_last_q;
      s3_h_d     = s3_h_q;
      sum = s2_p_q + (s2_p_q[63] ? NUDGE_NEG : NUDGE_POS);
      // biasing negatives before >>> turns the floor into truncation toward zero
      rnd = sum[63] ? sum + TRUNC_ADJ : sum;
      h   = s2_sat_q ? INT32_MAX : 32'(rnd >>> 31);
      if (en) begin
         s2_valid_d = in_valid;
         s3_valid_d = s2_valid_q;
         if (in_valid) begin
            s2_last_d = in_last;
            s2_p_d    = 64'(in_x) * 64'(in_mult);
            s2_sat_d  = (in_x == INT32_MIN) && (in_mult == INT32_MIN);
         end
         if (s2_valid_q) begin
            s3_last_d = s2_last_q;
            s3_h_d    = h;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         s2_last_q  <= 1'b0;
         s2_sat_q   <= 1'b0;
         s2_p_q     <= '0;
         s3_valid_q <= 1'b0;
         s3_last_q  <= 1'b0;
         s3_h_q     <= '0;
      end else begin
         s2_valid_q <= s2_valid_d;
         s2_last_q  <= s2_last_d;
         s2_sat_q   <= s2_sat_d;
         s2_p_q     <= s2_p_d;
         s3_valid_q <= s3_valid_d;
         s3_last_q  <= s3_last_d;
         s3_h_q     <= s3_h_d;
      end
   end

   assign out_valid = s3_valid_q;
   assign out_last  = s3_last_q;
   assign out_h     = s3_h_q;
   assign busy      = s2_valid_q | s3_valid_q;

endmodule

// File: rtl/conv1d_requant.sv
// int32 accumulator -> int8 activation requantizer, 4-stage valid/ready pipe.
module conv1d_requant
   import conv1d_pkg::*;
#(
   parameter int SHIFT_MAX = 31
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cfg_en,
   input  logic [2:0]                   cfg_sel,
   input  logic signed [INT32_SIZE-1:0] cfg_data,
   output logic                         cfg_err,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [INT32_SIZE-1:0] in_acc,
   input  logic                         in_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [BYTE_SIZE-1:0]         out_data,
   output logic                         out_last,
   output logic                         busy
);

   logic signed [INT32_SIZE-1:0] mult_q, mult_d, off_q, off_d;
   logic signed [INT32_SIZE-1:0] amin_q, amin_d, amax_q, amax_d;
   logic signed [SHIFT_W-1:0]    shift_q, shift_d;
   logic                         cfg_err_q, cfg_err_d;
   logic                         s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
   logic signed [INT32_SIZE-1:0] s1_x_q, s1_x_d;
   logic                         out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic [BYTE_SIZE-1:0]         out_data_q, out_data_d;
   logic                         s3_valid, s3_last, mid_busy, adv;
   logic signed [INT32_SIZE-1:0] s3_h, hs, r;
   logic [INT32_SIZE-1:0]        mask, rem, thr;
   logic [4:0]                   ls, rs;
   logic signed [INT32_SIZE:0]   v, lo, hi;

   assign adv      = !out_valid_q || out_ready;
   assign busy     = s1_valid_q || mid_busy || out_valid_q;
   assign in_ready = adv;

   always_comb begin
      mult_d    = mult_q;
      shift_d   = shift_q;
      off_d     = off_q;
      amin_d    = amin_q;
      amax_d    = amax_q;
      cfg_err_d = 1'b0;
      if (cfg_en) begin
         if (busy || cfg_sel > CFG_ACT_MAX) begin
            cfg_err_d = 1'b1;
         end else begin
            case (cfg_sel)
               CFG_MULT:    mult_d = cfg_data;
               CFG_SHIFT: begin
                  if (cfg_data > SHIFT_MAX)       shift_d = SHIFT_W'(SHIFT_MAX);
                  else if (cfg_data < -SHIFT_MAX) shift_d = SHIFT_W'(-SHIFT_MAX);
                  else                            shift_d = cfg_data[SHIFT_W-1:0];
               end
               CFG_OFFSET:  off_d  = cfg_data;
               CFG_ACT_MIN: amin_d = cfg_data;
               CFG_ACT_MAX: amax_d = cfg_data;
               default: ;
            endcase
         end
      end
   end

   // S1 uses the next-state shift so a same-cycle config write applies
   always_comb begin
      ls         = shift_d[SHIFT_W-1] ? 5'd0 : shift_d[4:0];
      s1_valid_d = adv ? in_valid : s1_valid_q;
      s1_last_d  = s1_last_q;
      s1_x_d     = s1_x_q;
      if (adv && in_valid) begin
         s1_last_d = in_last;
         s1_x_d    = in_acc << ls;
      end
   end

   conv1d_srdhm u_srdhm (
      .clk       (clk),
      .rst       (rst),
      .en        (adv),
      .in_valid  (s1_valid_q),
      .in_last   (s1_last_q),
      .in_x      (s1_x_q),
      .in_mult   (mult_q),
      .out_valid (s3_valid),
      .out_last  (s3_last),
      .out_h     (s3_h),
      .busy      (mid_busy)
   );

   always_comb begin
      rs   = shift_q[SHIFT_W-1] ? 5'(-shift_q) : 5'd0;
      mask = (32'd1 << rs) - 32'd1;
      rem  = s3_h & mask;
      thr  = (mask >> 1) + {31'd0, s3_h[INT32_SIZE-1]};
      hs   = s3_h >>> rs;
      r    = hs + {31'd0, rem > thr};
      lo   = {amin_q[INT32_SIZE-1], amin_q};
      hi   = {amax_q[INT32_SIZE-1], amax_q};
      v    = {r[INT32_SIZE-1], r} + {off_q[INT32_SIZE-1], off_q};
      // upper bound first: an inverted range resolves to act_min
      if (v > hi) v = hi;
      if (v < lo) v = lo;
      out_valid_d = adv ? s3_valid : out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      if (adv && s3_valid) begin
         out_data_d = low_byte(v);
         out_last_d = s3_last;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mult_q      <= MULT_RST;
         shift_q     <= SHIFT_RST;
         off_q       <= OFFSET_RST;
         amin_q      <= ACT_MIN_RST;
         amax_q      <= ACT_MAX_RST;
         cfg_err_q   <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         s1_x_q      <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else begin
         mult_q      <= mult_d;
         shift_q     <= shift_d;
         off_q       <= off_d;
         amin_q      <= amin_d;
         amax_q      <= amax_d;
         cfg_err_q   <= cfg_err_d;
         s1_valid_q  <= s1_valid_d;
         s1_last_q   <= s1_last_d;
         s1_x_q      <= s1_x_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
      end
   end

   assign cfg_err   = cfg_err_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_conv1d_requant.sv
// Directed self-checking bench for conv1d_requant.
module tb_conv1d_requant;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_en = 1'b0;
   logic [2:0]  cfg_sel = '0;
   logic [31:0] cfg_data = '0;
   logic        cfg_err;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_acc = '0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  out_data;
   logic        out_last;
   logic        busy;

   int errors = 0;
   int checks = 0;

   conv1d_requant dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_en    (cfg_en),
      .cfg_sel   (cfg_sel),
      .cfg_data  (cfg_data),
      .cfg_err   (cfg_err),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_acc    (in_acc),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [2:0] sel, input logic [31:0] data,
                            output logic err);
      cfg_en = 1'b1;
      cfg_sel = sel;
      cfg_data = data;
      step();
      err = cfg_err;
      cfg_en = 1'b0;
   endtask

   // one element through an idle pipe; lat counts edges incl. the capture edge
   task automatic send_get(input logic [31:0] acc, output logic [7:0] res,
                           output int lat);
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_acc = acc;
      in_last = 1'b0;
      step();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
      if (out_valid) res = out_data;
      else begin
         res = 'x;
         lat = 99;
      end
      step();
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data got=%h exp=00", out_data); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got=%b exp=0", out_last); end
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL rst_cfg_err got=%b exp=0", cfg_err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
      rst = 1'b0;
      step();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_basic;
      logic [7:0] res;
      int lat;
      logic err;
      send_get(32'd100, res, lat);
      checks++; if (res !== 8'd50) begin errors++; $display("FAIL basic_100 got=%h exp=32", res); end
      checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency got=%0d exp=4", lat); end
      cfg_write(CFG_SHIFT_SEL(), 32'd2, err);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_cfg_err got=%b exp=0", err); end
      send_get(32'd10, res, lat);
      checks++; if (res !== 8'd20) begin errors++; $display("FAIL basic_shl2 got=%h exp=14", res); end
   endtask

   function automatic logic [2:0] CFG_SHIFT_SEL();
      return 3'd1;
   endfunction

   task automatic test_rounding;
      logic [7:0] res;
      int lat;
      logic err;
      cfg_write(3'd1, 32'hffff_ffff, err);
      send_get(32'd6, res, lat);
      checks++; if (res !== 8'h02) begin errors++; $display("FAIL round_6 got=%h exp=02", res); end
      send_get(-32'sd6, res, lat);
      checks++; if (res !== 8'hfe) begin errors++; $display("FAIL round_m6 got=%h exp=fe", res); end
      send_get(32'd4, res, lat);
      checks++; if (res !== 8'h01) begin errors++; $display("FAIL round_4 got=%h exp=01", res); end
      send_get(-32'sd3, res, lat);
      checks++; if (res !== 8'hff) begin errors++; $display("FAIL round_m3 got=%h exp=ff", res); end
      cfg_write(3'd1, 32'hffff_fffe, err);
      send_get(-32'sd10, res, lat);
      checks++; if (res !== 8'hff) begin errors++; $display("FAIL round_m10_rs2 got=%h exp=ff", res); end
      cfg_write(3'd1, 32'd0, err);
   endtask

   task automatic test_saturation;
      logic [7:0] res;
      int lat;
      logic err;
      cfg_write(3'd0, 32'h8000_0000, err);
      send_get(32'h8000_0000, res, lat);
      checks++; if (res !== 8'h7f) begin errors++; $display("FAIL sat_min_min got=%h exp=7f", res); end
      send_get(32'd100, res, lat);
      checks++; if (res !== 8'h9c) begin errors++; $display("FAIL neg_mult got=%h exp=9c", res); end
      cfg_write(3'd0, 32'h4000_0000, err);
   endtask

   task automatic test_offset_clamp;
      logic [7:0] res;
      int lat;
      logic err;
      cfg_write(3'd2, 32'hffff_ff80, err);
      send_get(32'd600, res, lat);
      checks++; if (res !== 8'h7f) begin errors++; $display("FAIL off_hi_clamp got=%h exp=7f", res); end
      send_get(-32'sd10, res, lat);
      checks++; if (res !== 8'h80) begin errors++; $display("FAIL off_lo_clamp got=%h exp=80", res); end
      send_get(32'd50, res, lat);
      checks++; if (res !== 8'h99) begin errors++; $display("FAIL off_50 got=%h exp=99", res); end
      send_get(32'd500, res, lat);
      checks++; if (res !== 8'h7a) begin errors++; $display("FAIL off_500 got=%h exp=7a", res); end
      cfg_write(3'd3, 32'd0, err);
      send_get(-32'sd10, res, lat);
      checks++; if (res !== 8'h00) begin errors++; $display("FAIL relu got=%h exp=00", res); end
      cfg_write(3'd2, 32'd0, err);
      cfg_write(3'd3, 32'd10, err);
      cfg_write(3'd4, 32'd5, err);
      send_get(32'd100, res, lat);
      checks++; if (res !== 8'h0a) begin errors++; $display("FAIL inverted_range got=%h exp=0a", res); end
      cfg_write(3'd3, 32'hffff_ff80, err);
      cfg_write(3'd4, 32'd127, err);
   endtask

   task automatic test_shift_sat;
      logic [7:0] res;
      int lat;
      logic err;
      cfg_write(3'd1, 32'd100, err);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL shift_sat_err got=%b exp=0", err); end
      send_get(32'd1, res, lat);
      checks++; if (res !== 8'h80) begin errors++; $display("FAIL shift_pos_sat got=%h exp=80", res); end
      cfg_write(3'd1, 32'hffff_ff9c, err);
      send_get(32'h7fff_ffff, res, lat);
      checks++; if (res !== 8'h01) begin errors++; $display("FAIL shift_neg_sat got=%h exp=01", res); end
      cfg_write(3'd1, 32'd0, err);
   endtask

   task automatic test_back_to_back;
      logic err;
      logic [7:0] got[$];
      logic lasts[$];
      int idx = 0;
      int nout = 0;
      int unstable = 0;
      logic stall = 1'b0;
      logic hold, infire, hl;
      logic [7:0] hd;
      cfg_write(3'd0, 32'h7fff_ffff, err);
      for (int cyc = 0; cyc < 40 && nout < 8; cyc++) begin
         in_valid = (idx < 8);
         in_acc = 32'(idx + 1);
         in_last = (idx == 7);
         out_ready = !(cyc >= 3 && cyc <= 6);
         #1;
         if (in_valid && !in_ready) stall = 1'b1;
         if (out_valid && out_ready) begin
            got.push_back(out_data);
            lasts.push_back(out_last);
            nout++;
         end
         infire = in_valid && in_ready;
         hold = out_valid && !out_ready;
         hd = out_data;
         hl = out_last;
         step();
         if (hold && (!out_valid || out_data !== hd || out_last !== hl)) unstable++;
         if (infire) idx++;
      end
      in_valid = 1'b0;
      in_last = 1'b0;
      out_ready = 1'b1;
      checks++; if (nout !== 8) begin errors++; $display("FAIL stream_count got=%0d exp=8", nout); end
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stream_backpressure got=%b exp=1", stall); end
      checks++; if (unstable !== 0) begin errors++; $display("FAIL stream_hold got=%0d exp=0", unstable); end
      for (int i = 0; i < got.size(); i++) begin
         checks++; if (got[i] !== 8'(i + 1)) begin errors++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, got[i], 8'(i + 1)); end
         checks++; if (lasts[i] !== (i == 7)) begin errors++; $display("FAIL stream_last[%0d] got=%b exp=%b", i, lasts[i], i == 7); end
      end
   endtask

   task automatic test_cfg_busy;
      logic [7:0] res;
      int lat;
      int n;
      logic err;
      in_valid = 1'b1;
      in_acc = 32'd20;
      step();
      in_valid = 1'b0;
      cfg_write(3'd0, 32'h0001_2345, err);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL busy_cfg_err got=%b exp=1", err); end
      step();
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_pulse got=%b exp=0", cfg_err); end
      n = 0;
      while (busy && n < 20) begin
         step();
         n++;
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_drain got=%b exp=0", busy); end
      send_get(32'd20, res, lat);
      checks++; if (res !== 8'd20) begin errors++; $display("FAIL mult_unchanged got=%h exp=14", res); end
      cfg_write(3'd6, 32'd0, err);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL reserved_sel got=%b exp=1", err); end
      cfg_en = 1'b1;
      cfg_sel = 3'd1;
      cfg_data = 32'd1;
      in_valid = 1'b1;
      in_acc = 32'd5;
      step();
      cfg_en = 1'b0;
      in_valid = 1'b0;
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL same_cycle_err got=%b exp=0", cfg_err); end
      n = 0;
      while (!out_valid && n < 20) begin
         step();
         n++;
      end
      checks++; if (out_data !== 8'd10 || !out_valid) begin errors++; $display("FAIL same_cycle_cfg got=%h v=%b exp=0a", out_data, out_valid); end
      step();
      cfg_write(3'd1, 32'd0, err);
   endtask

   task automatic test_reset_midstream;
      logic [7:0] res;
      int lat;
      int seen = 0;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_acc = 32'(i + 1);
         step();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      step();
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (out_valid) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_stale got=%0d exp=0", seen); end
      send_get(32'd100, res, lat);
      checks++; if (res !== 8'd50) begin errors++; $display("FAIL midrst_cfg_default got=%h exp=32", res); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_rounding();
      test_saturation();
      test_offset_clamp();
      test_shift_sat();
      test_back_to_back();
      test_cfg_busy();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
